// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for two data-memory masters: one registered command stage, reads returned 2 cycles after grant.
// DMEM_ARB_RANGE_CHK_EN: reject accesses with address bits above ADDR_MSB set (the requester gets an err pulse).
module dmem_arbiter #(
  parameter int unsigned PRIO_RESET = 0,
  parameter int unsigned ADDR_MSB   = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [1:0]  m0_wsel_i,
  input  logic [2:0]  m0_rsel_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [1:0]  m1_wsel_i,
  input  logic [2:0]  m1_rsel_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_dataw_o,
  output logic        mem_Wen_o,
  output logic [2:0]  mem_RSel_o,
  output logic [1:0]  mem_WSel_o,
  input  logic [31:0] mem_datar_i
);

  logic        prio_q, prio_d;
  logic        gnt0, gnt1, any_gnt, range_err, rd_fire;
  logic        cmd_valid_q, cmd_owner_q;
  logic        cmd_we_q, cmd_we_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic [1:0]  cmd_wsel_q, cmd_wsel_d;
  logic [2:0]  cmd_rsel_q, cmd_rsel_d;
  logic        m0_rvalid_q, m1_rvalid_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;

  always_comb begin
    gnt0        = m0_req_i & (~m1_req_i | ~prio_q);
    gnt1        = m1_req_i & (~m0_req_i | prio_q);
    any_gnt     = gnt0 | gnt1;
    // the winner drops to lowest priority; idle cycles keep the current order
    prio_d      = any_gnt ? gnt0 : prio_q;
    cmd_we_d    = gnt1 ? m1_we_i    : m0_we_i;
    cmd_addr_d  = gnt1 ? m1_addr_i  : m0_addr_i;
    cmd_wdata_d = gnt1 ? m1_wdata_i : m0_wdata_i;
    cmd_wsel_d  = gnt1 ? m1_wsel_i  : m0_wsel_i;
    cmd_rsel_d  = gnt1 ? m1_rsel_i  : m0_rsel_i;
    rd_fire     = cmd_valid_q & ~cmd_we_q;
  end

`ifdef DMEM_ARB_RANGE_CHK_EN
  logic cmd_err_q, m0_err_q, m1_err_q;

  assign range_err = |(cmd_addr_d >> (ADDR_MSB + 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_err_q <= 1'b0;
      m0_err_q  <= 1'b0;
      m1_err_q  <= 1'b0;
    end else begin
      cmd_err_q <= any_gnt & range_err;
      m0_err_q  <= cmd_err_q & ~cmd_owner_q;
      m1_err_q  <= cmd_err_q & cmd_owner_q;
    end
  end

  assign m0_err_o = m0_err_q;
  assign m1_err_o = m1_err_q;
`else
  assign range_err = 1'b0;
  assign m0_err_o  = 1'b0;
  assign m1_err_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q      <= 1'(PRIO_RESET);
      cmd_valid_q <= 1'b0;
      cmd_owner_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wsel_q  <= '0;
      cmd_rsel_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      prio_q <= prio_d;
      if (any_gnt) begin
        cmd_valid_q <= ~range_err;
        cmd_owner_q <= gnt1;
        cmd_we_q    <= cmd_we_d;
        cmd_addr_q  <= cmd_addr_d;
        cmd_wdata_q <= cmd_wdata_d;
        cmd_wsel_q  <= cmd_wsel_d;
        cmd_rsel_q  <= cmd_rsel_d;
      end else begin
        cmd_valid_q <= 1'b0;
      end
      m0_rvalid_q <= rd_fire & ~cmd_owner_q;
      m1_rvalid_q <= rd_fire & cmd_owner_q;
      if (rd_fire && !cmd_owner_q) m0_rdata_q <= mem_datar_i;
      if (rd_fire && cmd_owner_q)  m1_rdata_q <= mem_datar_i;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign mem_Wen_o   = cmd_valid_q & cmd_we_q;
  assign mem_addr_o  = cmd_addr_q;
  assign mem_dataw_o = cmd_wdata_q;
  assign mem_RSel_o  = cmd_rsel_q;
  assign mem_WSel_o  = cmd_wsel_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural little-endian data memory behind it.
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [1:0]  m0_wsel_i, m1_wsel_i;
  logic [2:0]  m0_rsel_i, m1_rsel_i;
  logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic [31:0] mem_addr_o, mem_dataw_o, mem_datar_i;
  logic        mem_Wen_o;
  logic [2:0]  mem_RSel_o;
  logic [1:0]  mem_WSel_o;

  logic [31:0] mem [2048];
  logic        pre_we;
  logic [10:0] pre_idx;
  logic [31:0] pre_val;

  int passed = 0;
  int total  = 0;

  dmem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_wsel_i(m0_wsel_i), .m0_rsel_i(m0_rsel_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_wsel_i(m1_wsel_i), .m1_rsel_i(m1_rsel_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .mem_addr_o(mem_addr_o), .mem_dataw_o(mem_dataw_o), .mem_Wen_o(mem_Wen_o),
    .mem_RSel_o(mem_RSel_o), .mem_WSel_o(mem_WSel_o), .mem_datar_i(mem_datar_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (mem_Wen_o) begin
      case (mem_WSel_o)
        2'd0: mem[mem_addr_o[12:2]] <= mem_dataw_o;
        2'd1: if (mem_addr_o[1]) mem[mem_addr_o[12:2]][31:16] <= mem_dataw_o[15:0];
              else               mem[mem_addr_o[12:2]][15:0]  <= mem_dataw_o[15:0];
        default: mem[mem_addr_o[12:2]][8*mem_addr_o[1:0] +: 8] <= mem_dataw_o[7:0];
      endcase
    end
  end

  always_comb begin
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    w = mem[mem_addr_o[12:2]];
    h = mem_addr_o[1] ? w[31:16] : w[15:0];
    case (mem_addr_o[1:0])
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    case (mem_RSel_o)
      3'd1: mem_datar_i = {{16{h[15]}}, h};
      3'd2: mem_datar_i = {{24{b[7]}}, b};
      3'd3: mem_datar_i = {16'h0, h};
      3'd4: mem_datar_i = {24'h0, b};
      default: mem_datar_i = w;
    endcase
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    m0_req_i = 0; m0_we_i = 0; m0_addr_i = 0; m0_wdata_i = 0; m0_wsel_i = 0; m0_rsel_i = 0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_i = 0; m1_wdata_i = 0; m1_wsel_i = 0; m1_rsel_i = 0;
  endtask

  task automatic set_m0(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] ws, input logic [2:0] rs);
    m0_req_i = 1; m0_we_i = we; m0_addr_i = addr; m0_wdata_i = wd; m0_wsel_i = ws; m0_rsel_i = rs;
  endtask

  task automatic set_m1(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] ws, input logic [2:0] rs);
    m1_req_i = 1; m1_we_i = we; m1_addr_i = addr; m1_wdata_i = wd; m1_wsel_i = ws; m1_rsel_i = rs;
  endtask

  task automatic preload(input logic [10:0] idx, input logic [31:0] val);
    pre_idx = idx; pre_val = val; pre_we = 1;
    tick();
    pre_we = 0;
  endtask

  task automatic reset_dut();
    idle();
    rst_i = 1;
    tick();
    rst_i = 0;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({mem_Wen_o, mem_addr_o, mem_dataw_o, mem_RSel_o, mem_WSel_o} !== '0)
      $display("FAIL rst_mem: got wen=%b addr=%h dataw=%h rsel=%h wsel=%h expected all 0",
               mem_Wen_o, mem_addr_o, mem_dataw_o, mem_RSel_o, mem_WSel_o); else passed++;
    total++; if ({m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o} !== 4'b0)
      $display("FAIL rst_flags: got rvalid=%b%b err=%b%b expected 0000", m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o); else passed++;
    total++; if ({m0_rdata_o, m1_rdata_o} !== 64'h0)
      $display("FAIL rst_rdata: got %h %h expected 0 0", m0_rdata_o, m1_rdata_o); else passed++;
    tick();
    rst_i = 0;
    set_m0(0, 32'h0, 0, 0, 0);
    set_m1(0, 32'h4, 0, 0, 0);
    #1;
    total++; if ({m0_gnt_o, m1_gnt_o} !== 2'b10)
      $display("FAIL rst_prio: got gnt=%b%b expected 10", m0_gnt_o, m1_gnt_o); else passed++;
    idle();
    tick();
  endtask

  task automatic test_write_read();
    set_m0(1, 32'h100, 32'hDEADBEEF, 2'd0, 3'd0);
    #1;
    total++; if ({m0_gnt_o, m1_gnt_o} !== 2'b10)
      $display("FAIL wr_gnt: got %b%b expected 10", m0_gnt_o, m1_gnt_o); else passed++;
    tick();
    total++; if ({mem_Wen_o, mem_addr_o, mem_dataw_o, mem_WSel_o} !== {1'b1, 32'h100, 32'hDEADBEEF, 2'd0})
      $display("FAIL wr_drive: got wen=%b addr=%h dataw=%h wsel=%h expected 1 100 deadbeef 0",
               mem_Wen_o, mem_addr_o, mem_dataw_o, mem_WSel_o); else passed++;
    set_m0(0, 32'h100, 0, 2'd0, 3'd0);
    #1;
    total++; if (m0_gnt_o !== 1'b1)
      $display("FAIL rd_gnt: got %b expected 1", m0_gnt_o); else passed++;
    tick();
    idle();
    total++; if ({mem_Wen_o, mem_addr_o, m0_rvalid_o} !== {1'b0, 32'h100, 1'b0})
      $display("FAIL rd_drive: got wen=%b addr=%h rvalid=%b expected 0 100 0", mem_Wen_o, mem_addr_o, m0_rvalid_o); else passed++;
    tick();
    total++; if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o} !== {2'b10, 32'hDEADBEEF})
      $display("FAIL rd_data: got rvalid=%b%b rdata=%h expected 10 deadbeef", m0_rvalid_o, m1_rvalid_o, m0_rdata_o); else passed++;
    tick();
    total++; if ({m0_rvalid_o, m0_rdata_o} !== {1'b0, 32'hDEADBEEF})
      $display("FAIL rd_hold: got rvalid=%b rdata=%h expected 0 deadbeef", m0_rvalid_o, m0_rdata_o); else passed++;
  endtask

  task automatic test_round_robin();
    preload(11'h0C0, 32'hA0A0A0A0);
    preload(11'h0C1, 32'hB1B1B1B1);
    reset_dut();
    set_m0(0, 32'h300, 0, 0, 3'd0);
    set_m1(0, 32'h304, 0, 0, 3'd0);
    for (int k = 0; k < 8; k++) begin
      #1;
      total++; if ({m0_gnt_o, m1_gnt_o} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL rr_gnt[%0d]: got %b%b", k, m0_gnt_o, m1_gnt_o); else passed++;
      if (k >= 2) begin
        total++; if ({m0_rvalid_o, m1_rvalid_o} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
          $display("FAIL rr_rvalid[%0d]: got %b%b", k, m0_rvalid_o, m1_rvalid_o); else passed++;
        total++; if (((k % 2 == 0) ? m0_rdata_o : m1_rdata_o) !== ((k % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1))
          $display("FAIL rr_rdata[%0d]: got %h %h", k, m0_rdata_o, m1_rdata_o); else passed++;
      end
      tick();
    end
    idle();
    tick();
    tick();
  endtask

  task automatic test_same_word_prio1();
    preload(11'h080, 32'h11223344);
    reset_dut();
    set_m0(0, 32'h0, 0, 0, 3'd0);
    #1;
    total++; if ({m0_gnt_o, m1_gnt_o} !== 2'b10)
      $display("FAIL p1_setup: got %b%b expected 10", m0_gnt_o, m1_gnt_o); else passed++;
    tick();
    set_m0(0, 32'h203, 0, 0, 3'd4);
    set_m1(1, 32'h203, 32'h5A, 2'd2, 3'd0);
    #1;
    total++; if ({m0_gnt_o, m1_gnt_o} !== 2'b01)
      $display("FAIL p1_gnt_w: got %b%b expected 01", m0_gnt_o, m1_gnt_o); else passed++;
    tick();
    m1_req_i = 0;
    #1;
    total++; if ({m0_gnt_o, m1_gnt_o} !== 2'b10)
      $display("FAIL p1_gnt_r: got %b%b expected 10", m0_gnt_o, m1_gnt_o); else passed++;
    tick();
    idle();
    total++; if (mem[11'h080] !== 32'h5A223344)
      $display("FAIL p1_mem: got %h expected 5a223344", mem[11'h080]); else passed++;
    tick();
    total++; if ({m0_rvalid_o, m0_rdata_o} !== {1'b1, 32'h0000005A})
      $display("FAIL p1_rdata: got rvalid=%b rdata=%h expected 1 0000005a", m0_rvalid_o, m0_rdata_o); else passed++;
    tick();
  endtask

  task automatic test_same_word_prio0();
    preload(11'h080, 32'h11223344);
    reset_dut();
    set_m0(0, 32'h203, 0, 0, 3'd4);
    set_m1(1, 32'h203, 32'h5A, 2'd2, 3'd0);
    #1;
    total++; if ({m0_gnt_o, m1_gnt_o} !== 2'b10)
      $display("FAIL p0_gnt_r: got %b%b expected 10", m0_gnt_o, m1_gnt_o); else passed++;
    tick();
    m0_req_i = 0;
    #1;
    total++; if ({m0_gnt_o, m1_gnt_o} !== 2'b01)
      $display("FAIL p0_gnt_w: got %b%b expected 01", m0_gnt_o, m1_gnt_o); else passed++;
    tick();
    idle();
    total++; if ({m0_rvalid_o, m0_rdata_o} !== {1'b1, 32'h00000011})
      $display("FAIL p0_rdata: got rvalid=%b rdata=%h expected 1 00000011", m0_rvalid_o, m0_rdata_o); else passed++;
    tick();
    total++; if (mem[11'h080] !== 32'h5A223344)
      $display("FAIL p0_mem: got %h expected 5a223344", mem[11'h080]); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    preload(11'h010, 32'h12345678);
    reset_dut();
    set_m0(1, 32'h40, 32'hCAFEF00D, 2'd0, 3'd0);
    #1;
    total++; if (m0_gnt_o !== 1'b1)
      $display("FAIL rm_gnt: got %b expected 1", m0_gnt_o); else passed++;
    tick();
    idle();
    total++; if (mem_Wen_o !== 1'b1)
      $display("FAIL rm_pending: got wen=%b expected 1", mem_Wen_o); else passed++;
    rst_i = 1;
    #1;
    total++; if ({mem_Wen_o, mem_addr_o, mem_dataw_o} !== 65'h0)
      $display("FAIL rm_outputs: got wen=%b addr=%h dataw=%h expected 0 0 0", mem_Wen_o, mem_addr_o, mem_dataw_o); else passed++;
    tick();
    total++; if (mem[11'h010] !== 32'h12345678)
      $display("FAIL rm_mem: got %h expected 12345678", mem[11'h010]); else passed++;
    rst_i = 0;
    set_m0(0, 32'h0, 0, 0, 0);
    set_m1(0, 32'h4, 0, 0, 0);
    #1;
    total++; if ({m0_gnt_o, m1_gnt_o} !== 2'b10)
      $display("FAIL rm_prio: got %b%b expected 10", m0_gnt_o, m1_gnt_o); else passed++;
    idle();
    tick();
  endtask

  task automatic test_range();
    preload(11'h000, 32'hFFFFFFFF);
    reset_dut();
    set_m0(1, 32'h0000_4000, 32'h00000077, 2'd0, 3'd0);
    #1;
    total++; if ({m0_gnt_o, m1_gnt_o} !== 2'b10)
      $display("FAIL rg_gnt: got %b%b expected 10", m0_gnt_o, m1_gnt_o); else passed++;
    tick();
    idle();
`ifdef DMEM_ARB_RANGE_CHK_EN
    total++; if ({mem_Wen_o, m0_err_o} !== 2'b00)
      $display("FAIL rg_nowrite: got wen=%b err=%b expected 0 0", mem_Wen_o, m0_err_o); else passed++;
    set_m0(0, 32'h0, 0, 0, 0);
    set_m1(0, 32'h4, 0, 0, 0);
    #1;
    total++; if ({m0_gnt_o, m1_gnt_o} !== 2'b01)
      $display("FAIL rg_prio: got %b%b expected 01", m0_gnt_o, m1_gnt_o); else passed++;
    tick();
    idle();
    total++; if ({m0_err_o, m0_rvalid_o} !== 2'b10)
      $display("FAIL rg_err: got err=%b rvalid=%b expected 1 0", m0_err_o, m0_rvalid_o); else passed++;
    tick();
    total++; if (m0_err_o !== 1'b0)
      $display("FAIL rg_err_end: got %b expected 0", m0_err_o); else passed++;
    total++; if (mem[11'h000] !== 32'hFFFFFFFF)
      $display("FAIL rg_mem: got %h expected ffffffff", mem[11'h000]); else passed++;
`else
    total++; if ({mem_Wen_o, mem_addr_o} !== {1'b1, 32'h0000_4000})
      $display("FAIL rg_alias_drive: got wen=%b addr=%h expected 1 00004000", mem_Wen_o, mem_addr_o); else passed++;
    tick();
    total++; if ({m0_err_o, m0_rvalid_o} !== 2'b00)
      $display("FAIL rg_noerr: got err=%b rvalid=%b expected 0 0", m0_err_o, m0_rvalid_o); else passed++;
    total++; if (mem[11'h000] !== 32'h00000077)
      $display("FAIL rg_alias_mem: got %h expected 00000077", mem[11'h000]); else passed++;
`endif
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1;
    pre_we = 0; pre_idx = 0; pre_val = 0;
    idle();
    test_reset();
    test_write_read();
    test_round_robin();
    test_same_word_prio1();
    test_same_word_prio0();
    test_reset_mid();
    test_range();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and command sequencer in front of the single-port data memory.
- Port 0 is the core load/store unit. Port 1 is the loader/debug/DMA master.
- Grants one access per cycle using round-robin priority and registers the winning command toward the memory.
- Captures read data and returns it to the issuing port with a fixed 2-cycle latency.

Parameters:
- PRIO_RESET, 0: port holding priority after reset (0 or 1).
- ADDR_MSB, 12: highest address bit decoded by the memory (word index is addr[ADDR_MSB:2]); used only by the optional range check.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- m0_req  in  1  port 0 request; held stable until granted.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  32  port 0 byte address.
- m0_wdata  in  32  port 0 store data.
- m0_wsel  in  2  port 0 store size: 0 word, 1 half, 2 byte.
- m0_rsel  in  3  port 0 load type: 0 word, 1 half, 2 byte, 3 half unsigned, 4 byte unsigned.
- m0_gnt  out  1  port 0 request accepted this cycle (combinational).
- m0_rvalid  out  1  port 0 read data valid (1-cycle pulse).
- m0_rdata  out  32  port 0 read data.
- m0_err  out  1  port 0 access rejected (optional feature only; tied 0 otherwise).
- m1_*  (same set as m0_*)  port 1 equivalents.
- mem_addr  out  32  memory address.
- mem_dataw  out  32  memory write data.
- mem_Wen  out  1  memory write enable.
- mem_RSel  out  3  memory load type.
- mem_WSel  out  2  memory store size.
- mem_datar  in  32  memory read data (combinational from mem_addr/mem_RSel).

Behaviour:
- Reset values (async, rst=1): all command registers 0, cmd_valid=0, mem_Wen=0, mem_addr/dataw/RSel/WSel=0, both rvalid=0, both rdata=0, both err=0, prio=PRIO_RESET.
- Arbitration, combinational in cycle N:
  - Only one request: it is granted.
  - Both request: the port equal to prio is granted.
  - No request: no grant.
  - At most one gnt is high per cycle.
- Priority update at the posedge ending cycle N: on any grant to port k, prio <= ~k. No grant leaves prio unchanged.
- Command stage at the posedge ending cycle N:
  - Granted port's we/addr/wdata/wsel/rsel are loaded into the command registers; cmd_valid <= 1; owner <= k.
  - No grant gives cmd_valid <= 0.
- Memory drive in cycle N+1:
  - mem_Wen = cmd_valid & cmd_we.
  - mem_addr, mem_dataw, mem_RSel and mem_WSel come straight from the command registers.
  - When cmd_valid=0, mem_Wen=0 and the other outputs hold their last value.
- Write: the memory commits at the posedge ending cycle N+1. Nothing is returned to the requester.
- Read: at the posedge ending cycle N+1, mem_datar is captured into the owner's rdata and the owner's rvalid <= 1 for cycle N+2. rdata holds its value until the next read for that port.
- Latency and throughput:
  - Read: gnt in cycle N gives rvalid in cycle N+2.
  - Sustained throughput is 1 access per cycle, with no bubbles across a mix of ports or of reads and writes.
- Ordering:
  - Accesses execute in grant order.
  - A write granted in N and a read of the same word granted in N+1: the read sees the new data.
  - A read granted in N and a write granted in N+1: the read sees the old data.
- Requester rule: req, and the attributes with it, must stay stable until gnt. Dropping req before gnt is legal; no access is issued.
- Reset mid-operation: any command in the command stage is discarded (no write occurs if rst is asserted before the commit edge). Pending rvalid pulses are dropped.

Optional Feature:
- Macro DMEM_ARB_RANGE_CHK_EN.
- Defined:
  - A granted request with any of addr[31:ADDR_MSB+1] nonzero is still granted and advances prio.
  - It is loaded with cmd_valid=0, so no memory write and no rvalid occur.
  - The requester's err pulses for 1 cycle in N+2.
- Undefined: no check is made, err outputs are tied 0, and the memory aliases high addresses.

Test Plan:
- Port 0 only: write word 0xDEADBEEF to 0x100 (N), then read word 0x100 (N+1) -> mem_Wen=1 in N+1; m0_rvalid in N+3 with m0_rdata=0xDEADBEEF.
- Both ports read continuously from reset with PRIO_RESET=0 -> grants alternate 0,1,0,1…; each port sees rvalid every other cycle with the correct data.
- Port 1 writes byte 0x5A to 0x203 while port 0 reads unsigned byte 0x203 in the same cycle (prio=1) -> write first, then port 0 rdata=0x0000005A; with prio=0, rdata returns the old value.
- rst asserted in the cycle after a write grant to 0x40 -> memory word 0x40 unchanged, all outputs at reset values, prio=PRIO_RESET.
- With DMEM_ARB_RANGE_CHK_EN, port 0 writes to 0x0000_4000 -> m0_gnt=1, mem_Wen stays 0, m0_err pulses in N+2, no rvalid.
